// File: rtl/snp_bus_arbiter.sv
// Snoop-bus arbiter: round-robin selection of one snoop request, broadcast to the
// other caches, timed collection of their responses and a merged reply to the requester.
module snp_bus_arbiter #(
  parameter int PADDR_WIDTH = 32,
  parameter int BLK_WIDTH   = 512,
  parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8),
  parameter int NUM_PORT    = 4,
  parameter int TIMEOUT     = 16,
  localparam int IDW        = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORT*3-1:0]         c_tx_snp_op,
  input  logic [NUM_PORT*SADDR_WIDTH-1:0] c_tx_snp_addr,
  input  logic [NUM_PORT*BLK_WIDTH-1:0] c_tx_snp_data,
  input  logic [NUM_PORT*2-1:0]         c_tx_snp_rsp,
  output logic [NUM_PORT*3-1:0]         c_rx_snp_op,
  output logic [NUM_PORT*SADDR_WIDTH-1:0] c_rx_snp_addr,
  output logic [NUM_PORT*BLK_WIDTH-1:0] c_rx_snp_data,
  output logic [NUM_PORT*2-1:0]         c_rx_snp_rsp,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id,
  output logic                          timeout_err,
  output logic                          proto_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_PORT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, RESP, GAP} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         id_q, id_d, last_q, last_d, sup_q, sup_d;
  logic [2:0]             op_q, op_d;
  logic [SADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_PORT-1:0]    done_q, done_d;
  logic                   clean_q, clean_d, have_q, have_d, multi_q, multi_d;
  logic [BLK_WIDTH-1:0]   sdata_q, sdata_d;

  logic [NUM_PORT*3-1:0]           rx_op_q, rx_op_d;
  logic [NUM_PORT*SADDR_WIDTH-1:0] rx_addr_q, rx_addr_d;
  logic [NUM_PORT*BLK_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [NUM_PORT*2-1:0]           rx_rsp_q, rx_rsp_d;
  logic                            busy_q, busy_d, terr_q, terr_d, perr_q, perr_d;
  logic [IDW-1:0]                  grant_q, grant_d;

  logic       found, all_done;
  int         idx, pick_i;
  logic [1:0] mrsp;

  always_comb begin
    state_d = state_q;  id_d = id_q;       op_d = op_q;       addr_d = addr_q;
    cnt_d = cnt_q;      done_d = done_q;   clean_d = clean_q; have_d = have_q;
    multi_d = multi_q;  sup_d = sup_q;     sdata_d = sdata_q; last_d = last_q;
    rx_op_d = '0;  rx_addr_d = '0;  rx_data_d = '0;  rx_rsp_d = '0;
    terr_d = 1'b0; perr_d = 1'b0;
    found = 1'b0;  all_done = 1'b1;  idx = 0;  pick_i = 0;  mrsp = 2'd0;

    case (state_q)
      IDLE: begin
        // Search starts one past the previous winner so every port gets a turn.
        for (int k = 1; k <= NUM_PORT; k++) begin
          idx = int'(last_q) + k;
          if (idx >= NUM_PORT) idx = idx - NUM_PORT;
          if (!found && c_tx_snp_op[idx*3 +: 3] != 3'd0) begin
            found  = 1'b1;
            pick_i = idx;
          end
        end
        if (found) begin
          id_d    = IDW'(pick_i);
          op_d    = c_tx_snp_op[pick_i*3 +: 3];
          addr_d  = c_tx_snp_addr[pick_i*SADDR_WIDTH +: SADDR_WIDTH];
          cnt_d   = CW'(1);
          done_d  = '0;
          clean_d = 1'b0;
          have_d  = 1'b0;
          multi_d = 1'b0;
          sup_d   = '0;
          sdata_d = '0;
          case (op_d)
            3'd1, 3'd2, 3'd3: begin
              state_d = COLLECT;
              for (int i = 0; i < NUM_PORT; i++) begin
                if (i != pick_i) begin
                  rx_op_d[i*3 +: 3]                   = op_d;
                  rx_addr_d[i*SADDR_WIDTH +: SADDR_WIDTH] = addr_d;
                end
              end
            end
            3'd4: begin
              state_d = RESP;
              rx_rsp_d[pick_i*2 +: 2] = 2'd1;
            end
            default: begin
              state_d = RESP;
              rx_rsp_d[pick_i*2 +: 2] = 2'd3;
              perr_d = 1'b1;
            end
          endcase
        end
      end

      COLLECT: begin
        for (int i = 0; i < NUM_PORT; i++) begin
          if (i != int'(id_q) && !done_q[i] && c_tx_snp_rsp[i*2 +: 2] != 2'd0) begin
            done_d[i] = 1'b1;
            if (c_tx_snp_rsp[i*2 +: 2] == 2'd1) clean_d = 1'b1;
            if (c_tx_snp_rsp[i*2 +: 2] == 2'd2) begin
              if (have_d) multi_d = 1'b1;
              // A late lower-index supplier still takes precedence over an earlier one.
              if (!have_d || IDW'(i) < sup_d) begin
                sup_d   = IDW'(i);
                sdata_d = c_tx_snp_data[i*BLK_WIDTH +: BLK_WIDTH];
              end
              have_d = 1'b1;
            end
          end
        end
        for (int i = 0; i < NUM_PORT; i++) begin
          if (i != int'(id_q) && !done_d[i]) all_done = 1'b0;
        end
        if (all_done || cnt_q == TO_CNT) begin
          state_d = RESP;
          terr_d  = !all_done;
          perr_d  = multi_d;
          mrsp    = have_d ? 2'd2 : (clean_d ? 2'd1 : 2'd3);
          rx_rsp_d[int'(id_q)*2 +: 2] = mrsp;
          if (have_d) rx_data_d[int'(id_q)*BLK_WIDTH +: BLK_WIDTH] = sdata_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
          for (int i = 0; i < NUM_PORT; i++) begin
            if (i != int'(id_q) && !done_d[i]) begin
              rx_op_d[i*3 +: 3]                   = op_q;
              rx_addr_d[i*SADDR_WIDTH +: SADDR_WIDTH] = addr_q;
            end
          end
        end
      end

      RESP: state_d = GAP;

      GAP: begin
        state_d = IDLE;
        last_d  = id_q;
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    grant_d = busy_d ? id_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;   id_q <= '0;     last_q <= LAST_RST;  sup_q <= '0;
      op_q <= '0;        addr_q <= '0;   cnt_q <= '0;         done_q <= '0;
      clean_q <= 1'b0;   have_q <= 1'b0; multi_q <= 1'b0;     sdata_q <= '0;
      rx_op_q <= '0;     rx_addr_q <= '0; rx_data_q <= '0;    rx_rsp_q <= '0;
      busy_q <= 1'b0;    terr_q <= 1'b0; perr_q <= 1'b0;      grant_q <= '0;
    end else begin
      state_q <= state_d; id_q <= id_d;     last_q <= last_d;   sup_q <= sup_d;
      op_q <= op_d;       addr_q <= addr_d; cnt_q <= cnt_d;     done_q <= done_d;
      clean_q <= clean_d; have_q <= have_d; multi_q <= multi_d; sdata_q <= sdata_d;
      rx_op_q <= rx_op_d; rx_addr_q <= rx_addr_d; rx_data_q <= rx_data_d; rx_rsp_q <= rx_rsp_d;
      busy_q <= busy_d;   terr_q <= terr_d; perr_q <= perr_d;   grant_q <= grant_d;
    end
  end

  assign c_rx_snp_op   = rx_op_q;
  assign c_rx_snp_addr = rx_addr_q;
  assign c_rx_snp_data = rx_data_q;
  assign c_rx_snp_rsp  = rx_rsp_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign timeout_err   = terr_q;
  assign proto_err     = perr_q;

endmodule

// File: doc/snp_bus_arbiter.md
# snp_bus_arbiter

Parametrised snoop-bus arbiter and broadcaster connecting NUM_PORT MESI L1 cache controllers over their snoop channels. It selects one snoop request per transaction by round-robin and broadcasts it to all other caches. It then collects their snoop responses with a timeout and returns one merged response, plus any supplied data, to the requester. It sits between the per-cache snoop ports and generalises the single-cache snoop channel to N caches.

## Interface
- PADDR_WIDTH, 32, physical address width
- BLK_WIDTH, 512, cache block width in bits
- SADDR_WIDTH, PADDR_WIDTH-$clog2(BLK_WIDTH/8), block address width
- NUM_PORT, 4, number of caches (1..16)
- TIMEOUT, 16, max cycles in COLLECT (>=1)
- Derived: IDW = max(1, $clog2(NUM_PORT))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- c_tx_snp_op  in  NUM_PORT*3  request op from cache i (slice [i*3+:3])
- c_tx_snp_addr  in  NUM_PORT*SADDR_WIDTH  request block address
- c_tx_snp_data  in  NUM_PORT*BLK_WIDTH  writeback data (requester) or supplied data (responder)
- c_tx_snp_rsp  in  NUM_PORT*2  snoop response from cache i
- c_rx_snp_op  out  NUM_PORT*3  broadcast op to cache i
- c_rx_snp_addr  out  NUM_PORT*SADDR_WIDTH  broadcast address
- c_rx_snp_data  out  NUM_PORT*BLK_WIDTH  data returned to requester
- c_rx_snp_rsp  out  NUM_PORT*2  merged response to requester
- busy  out  1  state != IDLE
- grant_id  out  IDW  index of current requester
- timeout_err  out  1  one-cycle pulse on COLLECT timeout
- proto_err  out  1  one-cycle pulse on illegal op or multiple data suppliers

## Operation
- Op encoding: 0 NONE, 1 RD (GetS), 2 RDX (GetX), 3 UPG, 4 WB, 5-7 illegal.
- Snooper rsp encoding: 0 NONE (not yet), 1 HIT_CLEAN, 2 HIT_DATA, 3 MISS.
- Merged rsp to requester: 2 DATA if any snooper gave HIT_DATA; otherwise 1 SHARED if any gave HIT_CLEAN; otherwise 3 EXCL (no other copy, or timeout).
- Requesters hold op/addr/data stable until they see nonzero c_rx_snp_rsp, then drop op to 0 the next cycle.
- FSM states:
  - IDLE: pick a requester among ports with op != 0, round-robin starting at last_grant+1. Latch id, op, addr.
    - RD/RDX/UPG -> COLLECT.
    - WB or illegal -> RESP. WB yields rsp 1. Illegal yields rsp 3 plus proto_err.
  - COLLECT: drive latched op/addr to every non-requester port that has not yet responded. On a port's first nonzero rsp, record it and drive op 0 to that port from the next cycle.
    - Exit to RESP when all non-requesters have responded, or when the cycle counter reaches TIMEOUT. On timeout, non-responders count as MISS and timeout_err pulses.
  - RESP: for one cycle, drive the merged rsp on the requester port. Drive c_rx_snp_data from the lowest-index HIT_DATA responder (zeros if none). More than one HIT_DATA responder pulses proto_err and the lowest index still wins. -> GAP.
  - GAP: one cycle with all outputs 0. Update last_grant. -> IDLE.
- Data is captured when a responder's rsp is recorded.
- NUM_PORT=1: COLLECT exits on its first cycle with rsp 3.
- Requester's own c_rx_snp_op is always 0.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, last_grant = NUM_PORT-1 (port 0 first), counters and flags 0.
- Request sampled at edge E0 -> snoop op visible after E0.
- Responses present before E1 -> RESP after E1 -> rsp visible for exactly one cycle.
- Minimum request-to-rsp latency is 2 edges; WB takes 1 edge.
- Timeout counter starts at 1 on the first COLLECT cycle, so RESP is entered at the edge where count == TIMEOUT.
- A response and the timeout on the same edge: the response is counted, and timeout_err pulses only if a non-responder remains.
- Requests arriving during a transaction wait; no request is lost while held.
- rst asserted mid-transaction: immediate return to reset values. Requesters re-issue.

## Test plan
- NUM_PORT=4: port 1 RD addr 0x155, ports 0/2/3 answer MISS on the first COLLECT cycle -> port 1 gets rsp 3 two edges after the request, data 0, and the other ports saw op 1, addr 0x155 for one cycle.
- Port 0 RDX, port 3 answers HIT_DATA with data 0xA5.., the others HIT_CLEAN -> port 0 gets rsp 2 with data 0xA5.., no errors.
- All four ports request simultaneously, held -> grants in order 0,1,2,3, each transaction separated by one GAP cycle.
- Port 2 RD, port 1 never responds, TIMEOUT=16 -> RESP after 16 COLLECT cycles, timeout_err pulses once, rsp merged from the remaining ports.
- Port 0 op 6 -> rsp 3 after one edge, proto_err pulse, no broadcast. Port 1 WB -> rsp 1, no broadcast.
- rst asserted during COLLECT -> all outputs 0 in the same cycle. The next grant after release goes to port 0.
